// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and widths for the Dcache snooping-bus arbiter
//
// Contents:
//   DCACHE_TAG_W / DCACHE_IDX_W  request tag and index widths; a line address
//                                is {tag, idx, 3'b000} and spans 64 bits
//   RSP_Q_PTR_W                  default response-queue pointer width
//   message_t                    coherence request type on the bus
//   bus_arb_state_t              arbiter FSM states
//   line_addr()                  builds the 64-bit line address from tag/idx
package bus_pkg;

    localparam int DCACHE_TAG_W = 52;
    localparam int DCACHE_IDX_W = 9;
    localparam int RSP_Q_PTR_W  = 3;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        GET_S = 2'd1,
        GET_M = 2'd2,
        PUT_M = 2'd3
    } message_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } bus_arb_state_t;

    function automatic logic [63:0] line_addr(input logic [DCACHE_TAG_W-1:0] tag,
                                              input logic [DCACHE_IDX_W-1:0] idx);
        return {tag, idx, 3'b000};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req      request vector, one bit per requester
//   pri_ptr  requester that holds highest priority this cycle
//   gnt      one-hot grant (all zero when nothing requests)
//   gnt_idx  encoded index of the granted requester
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pri_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan requesters in priority order pri_ptr, pri_ptr+1, ... (wrapping);
    // the first active one wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(pri_ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dcache_bus_arb.sv
// rtl/dcache_bus_arb.sv - snooping-bus arbiter/sequencer between core Dcaches and Dmem controller
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   req_*_i                   per-core request (valid held until req_gnt_o)
//   req_gnt_o, req_ptr_o      one-cycle commit pulse and the queue pointer assigned
//   bus_req_*_o, bus_rsp_ptr_o broadcast of the transaction being sequenced
//   bus_req_core_ack_i        a peer core will supply the data
//   Dmem_ctrl_rsp_ack_i       memory controller accepts the broadcast
//   bus_req_ack_o             commit strobe to the memory controller
//   Dmem_ctrl_rsp_*_i         memory data return
//   core_rsp_*_i/_ack_o       peer-core data return and its acceptance
//   bus_rsp_*_o               peer writeback forwarded to memory
//   rsp_vld_o/ptr_o/data_o    data delivery to the owning requester
module dcache_bus_arb
    import bus_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int RSP_Q_NUM   = 8,
    parameter int RSP_Q_PTR_W = bus_pkg::RSP_Q_PTR_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req_vld_i,
    input  logic [NUM_REQ-1:0][DCACHE_TAG_W-1:0]    req_tag_i,
    input  logic [NUM_REQ-1:0][DCACHE_IDX_W-1:0]    req_idx_i,
    input  message_t [NUM_REQ-1:0]                  req_msg_i,
    input  logic [NUM_REQ-1:0][63:0]                req_data_i,
    output logic [NUM_REQ-1:0]                      req_gnt_o,
    output logic [RSP_Q_PTR_W-1:0]                  req_ptr_o,
    output logic [DCACHE_TAG_W-1:0]                 bus_req_tag_o,
    output logic [DCACHE_IDX_W-1:0]                 bus_req_idx_o,
    output message_t                                bus_req_message_o,
    output logic [63:0]                             bus_req_data_o,
    output logic [RSP_Q_PTR_W-1:0]                  bus_rsp_ptr_o,
    input  logic                                    bus_req_core_ack_i,
    input  logic                                    Dmem_ctrl_rsp_ack_i,
    output logic                                    bus_req_ack_o,
    input  logic                                    Dmem_ctrl_rsp_vld_i,
    input  logic [RSP_Q_PTR_W-1:0]                  Dmem_ctrl_rsp_ptr_i,
    input  logic [63:0]                             Dmem_ctrl_rsp_data_i,
    input  logic                                    core_rsp_vld_i,
    input  logic [RSP_Q_PTR_W-1:0]                  core_rsp_ptr_i,
    input  logic [63:0]                             core_rsp_data_i,
    output logic                                    core_rsp_ack_o,
    output logic                                    bus_rsp_vld_o,
    output logic [63:0]                             bus_rsp_addr_o,
    output logic [63:0]                             bus_rsp_data_o,
    output logic [NUM_REQ-1:0]                      rsp_vld_o,
    output logic [RSP_Q_PTR_W-1:0]                  rsp_ptr_o,
    output logic [63:0]                             rsp_data_o
);

    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    bus_arb_state_t               state;
    logic [OWN_W-1:0]             rr_ptr;
    logic [RSP_Q_NUM-1:0]         free_vec;
    logic [RSP_Q_NUM-1:0]         free_nxt;
    logic [OWN_W-1:0]             q_owner [RSP_Q_NUM];
    logic [63:0]                  q_addr  [RSP_Q_NUM];

    logic [DCACHE_TAG_W-1:0]      lat_tag;
    logic [DCACHE_IDX_W-1:0]      lat_idx;
    message_t                     lat_msg;
    logic [63:0]                  lat_data;
    logic [OWN_W-1:0]             lat_owner;
    logic [RSP_Q_PTR_W-1:0]       lat_ptr;

    logic [NUM_REQ-1:0]           arb_gnt;
    logic [OWN_W-1:0]             arb_idx;
    logic [RSP_Q_PTR_W-1:0]       alloc_ptr;
    logic                         do_alloc;
    logic                         commit;
    logic                         commit_free;
    logic                         rsp_free_en;
    logic [RSP_Q_PTR_W-1:0]       rsp_free_ptr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req     (req_vld_i),
        .pri_ptr (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Lowest-index free entry; only meaningful while free_vec is non-zero.
    always_comb begin
        alloc_ptr = '0;
        for (int i = RSP_Q_NUM - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_ptr = RSP_Q_PTR_W'(i);
        end
    end

    assign do_alloc = (state == IDLE) && (|arb_gnt) && (|free_vec);
    assign commit   = (state == BCAST) && Dmem_ctrl_rsp_ack_i;

    // A GET_S always waits for its data; a GET_M only does when a peer core
    // promised to supply it, otherwise memory answers without a queue entry.
    assign commit_free = commit &&
                         ((lat_msg == PUT_M) || ((lat_msg == GET_M) && !bus_req_core_ack_i));

    // Response routing: memory returns win; a peer return is only taken when
    // memory is silent, and it is mirrored to memory as a writeback.
    always_comb begin
        rsp_vld_o      = '0;
        rsp_ptr_o      = '0;
        rsp_data_o     = '0;
        core_rsp_ack_o = 1'b0;
        bus_rsp_vld_o  = 1'b0;
        bus_rsp_addr_o = '0;
        bus_rsp_data_o = '0;
        rsp_free_en    = 1'b0;
        rsp_free_ptr   = '0;
        if (Dmem_ctrl_rsp_vld_i) begin
            rsp_ptr_o  = Dmem_ctrl_rsp_ptr_i;
            rsp_data_o = Dmem_ctrl_rsp_data_i;
            if (!free_vec[Dmem_ctrl_rsp_ptr_i]) begin
                rsp_vld_o[q_owner[Dmem_ctrl_rsp_ptr_i]] = 1'b1;
                rsp_free_en  = 1'b1;
                rsp_free_ptr = Dmem_ctrl_rsp_ptr_i;
            end
        end else if (core_rsp_vld_i && !rst) begin
            core_rsp_ack_o = 1'b1;
            rsp_ptr_o      = core_rsp_ptr_i;
            rsp_data_o     = core_rsp_data_i;
            if (!free_vec[core_rsp_ptr_i]) begin
                rsp_vld_o[q_owner[core_rsp_ptr_i]] = 1'b1;
                bus_rsp_vld_o  = 1'b1;
                bus_rsp_addr_o = q_addr[core_rsp_ptr_i];
                bus_rsp_data_o = core_rsp_data_i;
                rsp_free_en    = 1'b1;
                rsp_free_ptr   = core_rsp_ptr_i;
            end
        end
    end

    // Allocation only picks entries already free in the register, so it never
    // collides with an entry being released in the same cycle.
    always_comb begin
        free_nxt = free_vec;
        if (rsp_free_en) free_nxt[rsp_free_ptr] = 1'b1;
        if (commit_free) free_nxt[lat_ptr] = 1'b1;
        if (do_alloc)    free_nxt[alloc_ptr] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            free_vec  <= '1;
            lat_tag   <= '0;
            lat_idx   <= '0;
            lat_msg   <= NONE;
            lat_data  <= '0;
            lat_owner <= '0;
            lat_ptr   <= '0;
        end else begin
            free_vec <= free_nxt;
            case (state)
                IDLE: begin
                    if (do_alloc) begin
                        lat_tag   <= req_tag_i[arb_idx];
                        lat_idx   <= req_idx_i[arb_idx];
                        lat_msg   <= req_msg_i[arb_idx];
                        lat_data  <= req_data_i[arb_idx];
                        lat_owner <= arb_idx;
                        lat_ptr   <= alloc_ptr;
                        state     <= BCAST;
                    end
                end
                BCAST: begin
                    if (commit) begin
                        rr_ptr <= (lat_owner == OWN_W'(NUM_REQ - 1)) ? '0 : lat_owner + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Queue payload needs no reset: an entry is only read while it is allocated.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            q_owner[alloc_ptr] <= arb_idx;
            q_addr[alloc_ptr]  <= line_addr(req_tag_i[arb_idx], req_idx_i[arb_idx]);
        end
    end

    assign bus_req_tag_o     = (state == BCAST) ? lat_tag  : '0;
    assign bus_req_idx_o     = (state == BCAST) ? lat_idx  : '0;
    assign bus_req_message_o = (state == BCAST) ? lat_msg  : NONE;
    assign bus_req_data_o    = (state == BCAST) ? lat_data : '0;
    assign bus_rsp_ptr_o     = (state == BCAST) ? lat_ptr  : '0;
    assign bus_req_ack_o     = commit;
    assign req_ptr_o         = commit ? lat_ptr : '0;

    always_comb begin
        req_gnt_o = '0;
        if (commit) req_gnt_o[lat_owner] = 1'b1;
    end

endmodule

// File: tb/tb_dcache_bus_arb.sv
// tb/tb_dcache_bus_arb.sv - self-checking bench for dcache_bus_arb
module tb_dcache_bus_arb;
    import bus_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_vld_i;
    logic [1:0][51:0]  req_tag_i;
    logic [1:0][8:0]   req_idx_i;
    message_t [1:0]    req_msg_i;
    logic [1:0][63:0]  req_data_i;
    logic [1:0]        req_gnt_o;
    logic [2:0]        req_ptr_o;
    logic [51:0]       bus_req_tag_o;
    logic [8:0]        bus_req_idx_o;
    message_t          bus_req_message_o;
    logic [63:0]       bus_req_data_o;
    logic [2:0]        bus_rsp_ptr_o;
    logic              bus_req_core_ack_i;
    logic              Dmem_ctrl_rsp_ack_i;
    logic              bus_req_ack_o;
    logic              Dmem_ctrl_rsp_vld_i;
    logic [2:0]        Dmem_ctrl_rsp_ptr_i;
    logic [63:0]       Dmem_ctrl_rsp_data_i;
    logic              core_rsp_vld_i;
    logic [2:0]        core_rsp_ptr_i;
    logic [63:0]       core_rsp_data_i;
    logic              core_rsp_ack_o;
    logic              bus_rsp_vld_o;
    logic [63:0]       bus_rsp_addr_o;
    logic [63:0]       bus_rsp_data_o;
    logic [1:0]        rsp_vld_o;
    logic [2:0]        rsp_ptr_o;
    logic [63:0]       rsp_data_o;

    dcache_bus_arb dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld_i), .req_tag_i(req_tag_i), .req_idx_i(req_idx_i),
        .req_msg_i(req_msg_i), .req_data_i(req_data_i),
        .req_gnt_o(req_gnt_o), .req_ptr_o(req_ptr_o),
        .bus_req_tag_o(bus_req_tag_o), .bus_req_idx_o(bus_req_idx_o),
        .bus_req_message_o(bus_req_message_o), .bus_req_data_o(bus_req_data_o),
        .bus_rsp_ptr_o(bus_rsp_ptr_o), .bus_req_core_ack_i(bus_req_core_ack_i),
        .Dmem_ctrl_rsp_ack_i(Dmem_ctrl_rsp_ack_i), .bus_req_ack_o(bus_req_ack_o),
        .Dmem_ctrl_rsp_vld_i(Dmem_ctrl_rsp_vld_i), .Dmem_ctrl_rsp_ptr_i(Dmem_ctrl_rsp_ptr_i),
        .Dmem_ctrl_rsp_data_i(Dmem_ctrl_rsp_data_i),
        .core_rsp_vld_i(core_rsp_vld_i), .core_rsp_ptr_i(core_rsp_ptr_i),
        .core_rsp_data_i(core_rsp_data_i), .core_rsp_ack_o(core_rsp_ack_o),
        .bus_rsp_vld_o(bus_rsp_vld_o), .bus_rsp_addr_o(bus_rsp_addr_o),
        .bus_rsp_data_o(bus_rsp_data_o),
        .rsp_vld_o(rsp_vld_o), .rsp_ptr_o(rsp_ptr_o), .rsp_data_o(rsp_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which queue slots are in use, who owns them, and the
    // line address each one refers to; plus whose turn it is.
    bit          m_busy  [8];
    int          m_owner [8];
    logic [63:0] m_addr  [8];
    int          m_rr;

    function automatic int m_lowest_free();
        for (int i = 0; i < 8; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int c);
        return (c == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
        m_rr = 0;
    endtask

    task automatic m_commit(input int core, input message_t msg, input int p,
                            input logic [51:0] tag, input logic [8:0] idx, input bit cack);
        m_rr       = (core + 1) % 2;
        m_owner[p] = core;
        m_addr[p]  = {tag, idx, 3'b000};
        m_busy[p]  = (msg == GET_S) || (msg == GET_M && cack);
    endtask

    task automatic idle_inputs();
        req_vld_i = '0; req_tag_i = '0; req_idx_i = '0; req_data_i = '0;
        req_msg_i[0] = NONE; req_msg_i[1] = NONE;
        bus_req_core_ack_i = 0; Dmem_ctrl_rsp_ack_i = 0;
        Dmem_ctrl_rsp_vld_i = 0; Dmem_ctrl_rsp_ptr_i = '0; Dmem_ctrl_rsp_data_i = '0;
        core_rsp_vld_i = 0; core_rsp_ptr_i = '0; core_rsp_data_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_clear();
    endtask

    // Drives one request from one core and acks it after ack_delay broadcast
    // cycles; returns what was observed. Starts and ends at posedge+1.
    task automatic issue(input int core, input message_t msg, input logic [51:0] tag,
                         input logic [8:0] idx, input logic [63:0] data,
                         input int ack_delay, input bit cack,
                         output logic [1:0] gnt, output logic [2:0] gptr,
                         output message_t bmsg, output logic [51:0] btag,
                         output logic [8:0] bidx, output logic [63:0] bdata,
                         output logic [2:0] bptr, output int latency,
                         output int bcycles, output bit hold_ok, output bit ok);
        int  n;
        bit  done;
        n = 0; done = 0; bcycles = 0; hold_ok = 1; latency = -1;
        gnt = '0; gptr = '0; bmsg = NONE; btag = '0; bidx = '0; bdata = '0; bptr = '0;
        req_vld_i[core] = 1'b1; req_tag_i[core] = tag; req_idx_i[core] = idx;
        req_msg_i[core] = msg; req_data_i[core] = data;
        while (!done && n < 40) begin
            @(negedge clk);
            if (bus_req_message_o != NONE) begin
                if (bcycles == 0) begin
                    latency = n; bmsg = bus_req_message_o; btag = bus_req_tag_o;
                    bidx = bus_req_idx_o; bdata = bus_req_data_o; bptr = bus_rsp_ptr_o;
                end else if (bus_req_message_o !== bmsg || bus_req_tag_o !== btag ||
                             bus_req_idx_o !== bidx || bus_rsp_ptr_o !== bptr) begin
                    hold_ok = 0;
                end
                if (bcycles >= ack_delay) begin
                    Dmem_ctrl_rsp_ack_i = 1'b1; bus_req_core_ack_i = cack;
                    #1;
                    gnt = req_gnt_o; gptr = req_ptr_o; done = 1;
                end else if (req_gnt_o !== 2'b00 || bus_req_ack_o !== 1'b0) begin
                    hold_ok = 0;
                end
                bcycles++;
            end
            n++;
            @(posedge clk);
            #1;
            Dmem_ctrl_rsp_ack_i = 1'b0; bus_req_core_ack_i = 1'b0;
            if (done) req_vld_i[core] = 1'b0;
        end
        if (!done) req_vld_i[core] = 1'b0;
        ok = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus_req_message_o !== NONE || bus_req_tag_o !== '0 || bus_req_idx_o !== '0 ||
            bus_req_data_o !== '0 || bus_rsp_ptr_o !== '0) begin
            errors++;
            $display("FAIL reset_bus: msg=%0d tag=%h ptr=%0d, required NONE/0/0",
                     bus_req_message_o, bus_req_tag_o, bus_rsp_ptr_o);
        end
        checks++;
        if (req_gnt_o !== 2'b00 || bus_req_ack_o !== 1'b0 || rsp_vld_o !== 2'b00 ||
            bus_rsp_vld_o !== 1'b0 || core_rsp_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: gnt=%b ack=%b rsp_vld=%b bus_rsp_vld=%b core_ack=%b, required all 0",
                     req_gnt_o, bus_req_ack_o, rsp_vld_o, bus_rsp_vld_o, core_rsp_ack_o);
        end
        do_reset();
    endtask

    task automatic test_single_get_s();
        logic [1:0] gnt; logic [2:0] gptr, bptr; message_t bmsg;
        logic [51:0] btag; logic [8:0] bidx; logic [63:0] bdata;
        int lat, bc; bit hold_ok, ok;
        logic [51:0] tag; logic [8:0] idx; logic [63:0] data;
        tag = {$urandom, $urandom}; idx = 9'($urandom); data = {$urandom, $urandom};
        issue(0, GET_S, tag, idx, data, 0, 0, gnt, gptr, bmsg, btag, bidx, bdata, bptr, lat, bc, hold_ok, ok);
        checks++;
        if (!ok || lat !== 1 || bmsg !== GET_S || bptr !== 3'd0) begin
            errors++;
            $display("FAIL single_bcast: ok=%0d latency=%0d msg=%0d ptr=%0d, required 1/1/GET_S/0",
                     ok, lat, bmsg, bptr);
        end
        checks++;
        if (btag !== tag || bidx !== idx || bdata !== data) begin
            errors++;
            $display("FAIL single_fields: tag=%h idx=%h data=%h, required %h %h %h",
                     btag, bidx, bdata, tag, idx, data);
        end
        checks++;
        if (gnt !== 2'b01 || gptr !== 3'd0) begin
            errors++;
            $display("FAIL single_gnt: gnt=%b ptr=%0d, required 01/0", gnt, gptr);
        end
        m_commit(0, GET_S, 0, tag, idx, 0);
        Dmem_ctrl_rsp_vld_i = 1'b1; Dmem_ctrl_rsp_ptr_i = 3'd0; Dmem_ctrl_rsp_data_i = 64'hDEAD;
        @(negedge clk);
        checks++;
        if (rsp_vld_o !== 2'b01 || rsp_data_o !== 64'hDEAD || rsp_ptr_o !== 3'd0) begin
            errors++;
            $display("FAIL single_rsp: vld=%b data=%h ptr=%0d, required 01/DEAD/0",
                     rsp_vld_o, rsp_data_o, rsp_ptr_o);
        end
        @(posedge clk); #1;
        Dmem_ctrl_rsp_vld_i = 1'b0;
        m_busy[0] = 0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] g_vec [3];
        logic [2:0] g_ptr [3];
        int         g_cyc [3];
        int         g, exp_core, exp_p;
        do_reset();
        g = 0;
        for (int c = 0; c < 2; c++) begin
            req_tag_i[c] = {$urandom, $urandom}; req_idx_i[c] = 9'($urandom); req_msg_i[c] = GET_S;
        end
        req_vld_i = 2'b11; Dmem_ctrl_rsp_ack_i = 1'b1;
        for (int cyc = 0; cyc < 12 && g < 3; cyc++) begin
            @(negedge clk);
            if (req_gnt_o !== 2'b00) begin
                g_vec[g] = req_gnt_o; g_ptr[g] = req_ptr_o; g_cyc[g] = cyc; g++;
            end
            @(posedge clk); #1;
        end
        Dmem_ctrl_rsp_ack_i = 1'b0; req_vld_i = 2'b00;
        checks++;
        if (g !== 3) begin
            errors++;
            $display("FAIL b2b_count: grants=%0d, required 3", g);
        end
        for (int k = 0; k < g; k++) begin
            exp_core = m_rr; exp_p = m_lowest_free();
            checks++;
            if (g_vec[k] !== onehot(exp_core) || g_ptr[k] !== 3'(exp_p)) begin
                errors++;
                $display("FAIL b2b_grant%0d: gnt=%b ptr=%0d, required %b/%0d",
                         k, g_vec[k], g_ptr[k], onehot(exp_core), exp_p);
            end
            m_commit(exp_core, GET_S, exp_p, req_tag_i[exp_core], req_idx_i[exp_core], 0);
            if (k > 0) begin
                checks++;
                if (g_cyc[k] - g_cyc[k-1] !== 2) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: gap=%0d, required 2", k, g_cyc[k] - g_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [1:0] gnt; logic [2:0] gptr, bptr; message_t bmsg;
        logic [51:0] btag; logic [8:0] bidx; logic [63:0] bdata;
        int lat, bc, exp_p; bit hold_ok, ok;
        logic [51:0] tag; logic [8:0] idx;
        tag = {$urandom, $urandom}; idx = 9'($urandom);
        exp_p = m_lowest_free();
        issue(1, GET_M, tag, idx, 64'h0, 3, 0, gnt, gptr, bmsg, btag, bidx, bdata, bptr, lat, bc, hold_ok, ok);
        checks++;
        if (!ok || bc !== 4 || !hold_ok || btag !== tag || bidx !== idx || bmsg !== GET_M) begin
            errors++;
            $display("FAIL hold_bus: ok=%0d cycles=%0d stable=%0d msg=%0d, required 1/4/1/GET_M",
                     ok, bc, hold_ok, bmsg);
        end
        checks++;
        if (gnt !== 2'b10 || gptr !== 3'(exp_p)) begin
            errors++;
            $display("FAIL hold_gnt: gnt=%b ptr=%0d, required 10/%0d", gnt, gptr, exp_p);
        end
        @(negedge clk);
        checks++;
        if (req_gnt_o !== 2'b00 || bus_req_message_o !== NONE) begin
            errors++;
            $display("FAIL hold_single_pulse: gnt=%b msg=%0d, required 00/NONE", req_gnt_o, bus_req_message_o);
        end
        @(posedge clk); #1;
        m_commit(1, GET_M, exp_p, tag, idx, 0);
    endtask

    task automatic test_drain();
        logic [63:0] d; bit use_core;
        for (int p = 0; p < 8; p++) begin
            if (m_busy[p]) begin
                d = {$urandom, $urandom}; use_core = 1'($urandom_range(0, 1));
                if (use_core) begin
                    core_rsp_vld_i = 1; core_rsp_ptr_i = 3'(p); core_rsp_data_i = d;
                end else begin
                    Dmem_ctrl_rsp_vld_i = 1; Dmem_ctrl_rsp_ptr_i = 3'(p); Dmem_ctrl_rsp_data_i = d;
                end
                @(negedge clk);
                checks++;
                if (rsp_vld_o !== onehot(m_owner[p]) || rsp_data_o !== d || rsp_ptr_o !== 3'(p)) begin
                    errors++;
                    $display("FAIL drain_rsp%0d: vld=%b data=%h ptr=%0d, required %b/%h/%0d",
                             p, rsp_vld_o, rsp_data_o, rsp_ptr_o, onehot(m_owner[p]), d, p);
                end
                if (use_core) begin
                    checks++;
                    if (core_rsp_ack_o !== 1'b1 || bus_rsp_vld_o !== 1'b1 ||
                        bus_rsp_addr_o !== m_addr[p] || bus_rsp_data_o !== d) begin
                        errors++;
                        $display("FAIL drain_wb%0d: ack=%b vld=%b addr=%h data=%h, required 1/1/%h/%h",
                                 p, core_rsp_ack_o, bus_rsp_vld_o, bus_rsp_addr_o, bus_rsp_data_o, m_addr[p], d);
                    end
                end
                @(posedge clk); #1;
                core_rsp_vld_i = 0; Dmem_ctrl_rsp_vld_i = 0;
                m_busy[p] = 0;
            end
        end
    endtask

    task automatic test_queue_full();
        logic [1:0] gnt; logic [2:0] gptr, bptr; message_t bmsg;
        logic [51:0] btag; logic [8:0] bidx; logic [63:0] bdata;
        int lat, bc, core, busy_seen, n, c9; bit hold_ok, ok, seen;
        logic [51:0] tag; logic [8:0] idx;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            core = $urandom_range(0, 1); tag = {$urandom, $urandom}; idx = 9'($urandom);
            issue(core, GET_S, tag, idx, 64'h0, 0, 0, gnt, gptr, bmsg, btag, bidx, bdata, bptr, lat, bc, hold_ok, ok);
            checks++;
            if (!ok || gnt !== onehot(core) || gptr !== 3'(m_lowest_free())) begin
                errors++;
                $display("FAIL fill%0d: ok=%0d gnt=%b ptr=%0d, required 1/%b/%0d",
                         k, ok, gnt, gptr, onehot(core), m_lowest_free());
            end
            m_commit(core, GET_S, m_lowest_free(), tag, idx, 0);
        end
        c9 = $urandom_range(0, 1); tag = {$urandom, $urandom}; idx = 9'($urandom);
        req_vld_i[c9] = 1; req_tag_i[c9] = tag; req_idx_i[c9] = idx; req_msg_i[c9] = GET_S;
        Dmem_ctrl_rsp_ack_i = 1;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_req_message_o !== NONE || req_gnt_o !== 2'b00) busy_seen++;
            @(posedge clk); #1;
        end
        Dmem_ctrl_rsp_ack_i = 0;
        checks++;
        if (busy_seen !== 0) begin
            errors++;
            $display("FAIL full_backpressure: active cycles=%0d, required 0", busy_seen);
        end
        Dmem_ctrl_rsp_vld_i = 1; Dmem_ctrl_rsp_ptr_i = 3'd3; Dmem_ctrl_rsp_data_i = 64'h1234;
        @(negedge clk);
        checks++;
        if (rsp_vld_o !== onehot(m_owner[3]) || rsp_data_o !== 64'h1234) begin
            errors++;
            $display("FAIL full_free_rsp: vld=%b data=%h, required %b/1234", rsp_vld_o, rsp_data_o, onehot(m_owner[3]));
        end
        @(posedge clk); #1;
        Dmem_ctrl_rsp_vld_i = 0; m_busy[3] = 0;
        n = 0; seen = 0;
        while (!seen && n < 6) begin
            @(negedge clk);
            if (bus_req_message_o != NONE) seen = 1; else begin @(posedge clk); #1; n++; end
        end
        checks++;
        if (!seen || n !== 1 || bus_rsp_ptr_o !== 3'd3) begin
            errors++;
            $display("FAIL full_realloc: seen=%0d wait=%0d ptr=%0d, required 1/1/3", seen, n, bus_rsp_ptr_o);
        end
        Dmem_ctrl_rsp_ack_i = 1; #1;
        checks++;
        if (req_gnt_o !== onehot(c9) || req_ptr_o !== 3'd3) begin
            errors++;
            $display("FAIL full_gnt: gnt=%b ptr=%0d, required %b/3", req_gnt_o, req_ptr_o, onehot(c9));
        end
        @(posedge clk); #1;
        Dmem_ctrl_rsp_ack_i = 0; req_vld_i = '0;
        m_commit(c9, GET_S, 3, tag, idx, 0);
        test_drain();
    endtask

    task automatic test_rsp_collision();
        logic [1:0] gnt; logic [2:0] gptr, bptr; message_t bmsg;
        logic [51:0] btag; logic [8:0] bidx; logic [63:0] bdata;
        int lat, bc, core; bit hold_ok, ok;
        logic [51:0] tag; logic [8:0] idx; logic [63:0] dm, cd;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            core = $urandom_range(0, 1); tag = {$urandom, $urandom}; idx = 9'($urandom);
            issue(core, GET_S, tag, idx, 64'h0, 0, 0, gnt, gptr, bmsg, btag, bidx, bdata, bptr, lat, bc, hold_ok, ok);
            m_commit(core, GET_S, k, tag, idx, 0);
        end
        dm = {$urandom, $urandom}; cd = {$urandom, $urandom};
        Dmem_ctrl_rsp_vld_i = 1; Dmem_ctrl_rsp_ptr_i = 3'd1; Dmem_ctrl_rsp_data_i = dm;
        core_rsp_vld_i = 1; core_rsp_ptr_i = 3'd2; core_rsp_data_i = cd;
        @(negedge clk);
        checks++;
        if (rsp_vld_o !== onehot(m_owner[1]) || rsp_data_o !== dm || rsp_ptr_o !== 3'd1 ||
            core_rsp_ack_o !== 1'b0 || bus_rsp_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL collide_mem: vld=%b data=%h ptr=%0d cack=%b wb=%b, required %b/%h/1/0/0",
                     rsp_vld_o, rsp_data_o, rsp_ptr_o, core_rsp_ack_o, bus_rsp_vld_o, onehot(m_owner[1]), dm);
        end
        @(posedge clk); #1;
        Dmem_ctrl_rsp_vld_i = 0; m_busy[1] = 0;
        @(negedge clk);
        checks++;
        if (rsp_vld_o !== onehot(m_owner[2]) || rsp_data_o !== cd || core_rsp_ack_o !== 1'b1 ||
            bus_rsp_vld_o !== 1'b1 || bus_rsp_addr_o !== m_addr[2] || bus_rsp_data_o !== cd) begin
            errors++;
            $display("FAIL collide_core: vld=%b cack=%b wb=%b addr=%h, required %b/1/1/%h",
                     rsp_vld_o, core_rsp_ack_o, bus_rsp_vld_o, bus_rsp_addr_o, onehot(m_owner[2]), m_addr[2]);
        end
        @(posedge clk); #1;
        core_rsp_vld_i = 0; m_busy[2] = 0;
        Dmem_ctrl_rsp_vld_i = 1; Dmem_ctrl_rsp_ptr_i = 3'd1;
        @(negedge clk);
        checks++;
        if (rsp_vld_o !== 2'b00) begin
            errors++;
            $display("FAIL drop_free_mem: vld=%b, required 00", rsp_vld_o);
        end
        @(posedge clk); #1;
        Dmem_ctrl_rsp_vld_i = 0;
        core_rsp_vld_i = 1; core_rsp_ptr_i = 3'd2;
        @(negedge clk);
        checks++;
        if (rsp_vld_o !== 2'b00 || bus_rsp_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_free_core: vld=%b wb=%b, required 00/0", rsp_vld_o, bus_rsp_vld_o);
        end
        @(posedge clk); #1;
        core_rsp_vld_i = 0;
        test_drain();
    endtask

    task automatic test_random();
        logic [1:0] gnt; logic [2:0] gptr, bptr; message_t bmsg, msg;
        logic [51:0] btag; logic [8:0] bidx; logic [63:0] bdata;
        int lat, bc, core, dly, e; bit hold_ok, ok, cack;
        logic [51:0] tag; logic [8:0] idx; logic [63:0] data;
        for (int it = 0; it < 16; it++) begin
            if (m_lowest_free() < 0) test_drain();
            core = $urandom_range(0, 1); msg = message_t'($urandom_range(1, 3));
            tag = {$urandom, $urandom}; idx = 9'($urandom); data = {$urandom, $urandom};
            dly = $urandom_range(0, 2); cack = (msg == GET_M) ? 1'($urandom_range(0, 1)) : 1'b0;
            e = m_lowest_free();
            issue(core, msg, tag, idx, data, dly, cack, gnt, gptr, bmsg, btag, bidx, bdata, bptr, lat, bc, hold_ok, ok);
            checks++;
            if (!ok || gnt !== onehot(core) || gptr !== 3'(e) || bptr !== 3'(e) || bmsg !== msg ||
                btag !== tag || bidx !== idx || bdata !== data || bc !== dly + 1 || !hold_ok) begin
                errors++;
                $display("FAIL random%0d: ok=%0d gnt=%b ptr=%0d msg=%0d cycles=%0d, required %b/%0d/%0d/%0d",
                         it, ok, gnt, gptr, bmsg, bc, onehot(core), e, msg, dly + 1);
            end
            m_commit(core, msg, e, tag, idx, cack);
        end
        test_drain();
    endtask

    task automatic test_reset_mid();
        int n; bit seen;
        logic [51:0] t0, t1;
        t0 = {$urandom, $urandom}; t1 = {$urandom, $urandom};
        req_vld_i[1] = 1; req_tag_i[1] = t1; req_msg_i[1] = GET_M;
        n = 0; seen = 0;
        while (!seen && n < 6) begin
            @(negedge clk);
            if (bus_req_message_o != NONE) seen = 1; else begin @(posedge clk); #1; n++; end
        end
        #2 rst = 1'b1; Dmem_ctrl_rsp_ack_i = 1'b1;
        #1;
        checks++;
        if (!seen || bus_req_message_o !== NONE || bus_req_tag_o !== '0 || bus_rsp_ptr_o !== '0 ||
            req_gnt_o !== 2'b00 || bus_req_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: seen=%0d msg=%0d gnt=%b ack=%b, required 1/NONE/00/0",
                     seen, bus_req_message_o, req_gnt_o, bus_req_ack_o);
        end
        Dmem_ctrl_rsp_ack_i = 1'b0; req_vld_i = '0;
        @(posedge clk); #1;
        rst = 1'b0; m_clear();
        req_vld_i = 2'b11; req_tag_i[0] = t0; req_msg_i[0] = GET_S; req_msg_i[1] = GET_S;
        n = 0; seen = 0;
        while (!seen && n < 6) begin
            @(negedge clk);
            if (bus_req_message_o != NONE) seen = 1; else begin @(posedge clk); #1; n++; end
        end
        Dmem_ctrl_rsp_ack_i = 1'b1; #1;
        checks++;
        if (!seen || req_gnt_o !== 2'b01 || req_ptr_o !== 3'd0 || bus_req_tag_o !== t0) begin
            errors++;
            $display("FAIL reset_restart: seen=%0d gnt=%b ptr=%0d, required 1/01/0", seen, req_gnt_o, req_ptr_o);
        end
        @(posedge clk); #1;
        Dmem_ctrl_rsp_ack_i = 1'b0; req_vld_i = '0;
        m_commit(0, GET_S, 0, t0, req_idx_i[0], 0);
        test_drain();
    endtask

    initial begin
        test_reset();
        test_single_get_s();
        test_back_to_back();
        test_drain();
        test_hold();
        test_queue_full();
        test_rsp_collision();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
